// File: rtl/ddr_cap_pkg.sv
// Shared constants and pair-assembly state encoding for the dual-edge capture deserialiser.
package ddr_cap_pkg;

    localparam int MODE_SDR = 0;
    localparam int MODE_DDR = 1;

    // IDLE/HAVE_RISE are used in DDR mode; LOW_HALF/HIGH_HALF are used in SDR mode.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HAVE_RISE = 2'd1,
        ST_LOW_HALF  = 2'd2,
        ST_HIGH_HALF = 2'd3
    } pair_state_t;

endpackage

// File: rtl/ddr_capture_deser_fifo.sv
// First-word fall-through FIFO with a registered head; head holds its last value while empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_nxt;
    logic             wr_en;
    logic             rd_en;

    assign level  = wr_ptr - rd_ptr;
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en  = pop && !empty;
    assign wr_en  = push && (!full || rd_en);
    assign rd_nxt = rd_ptr + (rd_en ? PTR_ONE : '0);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Head tracks the entry at the next read pointer; a write landing there is bypassed.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            rd_ptr <= rd_nxt;
            if (wr_en && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0])) begin
                head <= push_data;
            end else if (rd_nxt != wr_ptr) begin
                head <= mem[rd_nxt[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/ddr_capture_deser.sv
// Dual-edge input capture with XOR-merged q and a FIFO of assembled rise/fall (or SDR) sample pairs.
module ddr_capture_deser
    import ddr_cap_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int MODE  = MODE_DDR,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [WIDTH-1:0]         d,
    output logic [WIDTH-1:0]         q,
    output logic [2*WIDTH-1:0]       pair_data,
    output logic                     pair_valid,
    input  logic                     pair_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         ovf_cnt
);

    localparam pair_state_t ST_RST = (MODE == MODE_DDR) ? ST_IDLE : ST_LOW_HALF;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [WIDTH-1:0]   rise_x;
    logic [WIDTH-1:0]   fall_x;
    logic [WIDTH-1:0]   rise_smp;
    logic [WIDTH-1:0]   fall_smp;
    logic               fall_en;
    pair_state_t        state;
    pair_state_t        state_nxt;
    logic               push_req;
    logic [2*WIDTH-1:0] push_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop_ok;
    logic               drop;

    // Each edge stores d XOR the other edge's register, so the XOR of both is the latest sample.
    assign q = rise_x ^ fall_x;

    always_ff @(negedge clk) begin
        if (rst) begin
            fall_x   <= '0;
            fall_smp <= '0;
            fall_en  <= 1'b0;
        end else if (MODE == MODE_DDR) begin
            fall_en <= en;
            if (en) begin
                fall_x   <= d ^ rise_x;
                fall_smp <= d;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        push_req  = 1'b0;
        push_data = {fall_smp, rise_smp};
        if (MODE == MODE_DDR) begin
            push_req  = (state == ST_HAVE_RISE) && fall_en;
            state_nxt = en ? ST_HAVE_RISE : ST_IDLE;
        end else begin
            push_data = {d, rise_smp};
            if (en) begin
                if (state == ST_HIGH_HALF) begin
                    push_req  = 1'b1;
                    state_nxt = ST_LOW_HALF;
                end else begin
                    state_nxt = ST_HIGH_HALF;
                end
            end
        end
    end

    assign pop_ok = pair_ready && !fifo_empty;
    assign drop   = push_req && fifo_full && !pop_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_x   <= '0;
            rise_smp <= '0;
            state    <= ST_RST;
            ovf_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (en) begin
                rise_x <= d ^ fall_x;
            end
            // In SDR mode only the low half of a pair needs to be held.
            if (en && ((MODE == MODE_DDR) || (state != ST_HIGH_HALF))) begin
                rise_smp <= d;
            end
            if (drop) begin
                ovf_cnt <= sat_inc(ovf_cnt);
            end
        end
    end

    sync_fifo_fwft #(
        .WIDTH (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (push_data),
        .pop       (pair_ready),
        .head      (pair_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (level)
    );

    assign pair_valid = !fifo_empty;

endmodule
